// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 constants, FSM encoding and the single-byte CRC step used by the
// Ethernet FCS checker and its lane chain.
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  // Byte counter width; frames at or above 2^16-1 bytes simply read as "long".
  localparam int LEN_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } fcs_state_e;

  // Per-frame verdict carried from the compare logic into the status registers.
  typedef struct packed {
    logic fcs_ok;
    logic len_err;
  } fcs_stat_t;

  // Fold one byte into the CRC, wire order (bit 0 first), MSB-first register.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lane_chain.sv
// Combinational CRC over one beat: lane 0 first. crc_lane[k] is the CRC after
// folding lanes 0..k, so the caller can pick the result for any byte count.
module crc32_lane_chain
  import eth_crc_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic [31:0]                crc_in,
  input  logic [8*BYTES-1:0]         data,
  output logic [BYTES-1:0][31:0]     crc_lane
);

  // Serial fold of the lanes, tapping the running CRC after each one.
  always_comb begin
    logic [31:0] c;
    c        = crc_in;
    crc_lane = '0;
    for (int k = 0; k < BYTES; k++) begin
      c           = crc32_byte(c, data[8*k +: 8]);
      crc_lane[k] = c;
    end
  end

endmodule

// File: rtl/eth_fcs_checker.sv
// Ethernet RX FCS checker: passes the byte-lane stream through with one cycle of
// latency, checks CRC residue, length and framing per frame, emits one status
// pulse aligned with the frame's closing output beat, and keeps saturating
// good/bad frame counters plus a sticky protocol-error flag.
module eth_fcs_checker
  import eth_crc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int BCNT_W = $clog2(BYTES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BCNT_W-1:0] in_bcnt,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic [BCNT_W-1:0] out_bcnt,
  output logic              stat_valid,
  output logic              stat_fcs_ok,
  output logic              stat_len_err,
  output logic [CNT_W-1:0]  cnt_good,
  output logic [CNT_W-1:0]  cnt_bad,
  output logic              proto_err
);

  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(BYTES);

  fcs_state_e              state_q, state_d;
  logic [31:0]             crc_q, crc_d;
  logic [LEN_W-1:0]        len_q, len_d;

  logic [31:0]             crc_base;
  logic [LEN_W-1:0]        len_base;
  logic [BYTES-1:0][31:0]  crc_lane;
  logic [31:0]             crc_fold;
  logic [BCNT_W-1:0]       n_fold;
  logic [LEN_W:0]          len_sum;
  logic [LEN_W-1:0]        len_tot;
  logic                    bcnt_bad;
  logic                    keep, trunc, fin, proto_set;
  logic                    stat_v;
  fcs_stat_t               stat_d;

  // A sop beat always restarts the CRC and byte count, whatever state we are in.
  assign crc_base = (in_sop || state_q == ST_IDLE) ? CRC32_INIT : crc_q;
  assign len_base = in_sop ? '0 : len_q;

  crc32_lane_chain #(.BYTES(BYTES)) u_chain (
    .crc_in   (crc_base),
    .data     (in_data),
    .crc_lane (crc_lane)
  );

  // Lane count to fold this beat and the matching tap of the lane chain.
  always_comb begin
    bcnt_bad = (in_bcnt == '0) || (in_bcnt > BCNT_FULL);
    n_fold   = (in_eop && !bcnt_bad) ? in_bcnt : BCNT_FULL;
    crc_fold = crc_lane[BYTES-1];
    for (int k = 0; k < BYTES; k++)
      if (n_fold == BCNT_W'(k + 1)) crc_fold = crc_lane[k];
    len_sum  = {1'b0, len_base} + (LEN_W + 1)'(n_fold);
    len_tot  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  end

  // Beat classification and FSM next state.
  // A sop+eop beat arriving mid-frame only reports the truncated old frame;
  // the one-beat new frame has no status slot left and is not counted.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    keep      = in_valid && (in_sop || state_q == ST_FRAME);
    proto_set = in_valid && !in_sop && state_q == ST_IDLE;
    trunc     = in_valid && in_sop && state_q == ST_FRAME;
    fin       = keep && in_eop && !trunc;
    stat_v    = trunc || fin;
    stat_d    = '0;
    if (trunc) begin
      stat_d.fcs_ok  = 1'b0;
      stat_d.len_err = 1'b1;
    end else if (fin) begin
      stat_d.fcs_ok  = (crc_fold == CRC32_RESIDUE);
      stat_d.len_err = bcnt_bad || ({{(32-LEN_W){1'b0}}, len_tot} < 32'(MIN_LEN));
    end
    if (keep) begin
      if (in_eop) begin
        state_d = ST_IDLE;
        crc_d   = CRC32_INIT;
        len_d   = '0;
      end else begin
        state_d = ST_FRAME;
        crc_d   = crc_fold;
        len_d   = len_tot;
      end
    end
  end

  // FSM, running CRC and byte count; idle cycles hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC32_INIT;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
    end
  end

  // One-cycle data pipeline; dropped beats leave out_valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_bcnt  <= '0;
    end else begin
      out_valid <= keep;
      out_sop   <= keep && in_sop;
      out_eop   <= keep && in_eop;
      out_data  <= in_data;
      out_bcnt  <= in_bcnt;
    end
  end

  // Status pulse lines up with the output beat that closed the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid   <= 1'b0;
      stat_fcs_ok  <= 1'b0;
      stat_len_err <= 1'b0;
    end else begin
      stat_valid   <= stat_v;
      stat_fcs_ok  <= stat_v && stat_d.fcs_ok;
      stat_len_err <= stat_v && stat_d.len_err;
    end
  end

  // Saturating frame counters, updated in the same cycle as the status pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else if (stat_v) begin
      if (stat_d.fcs_ok && !stat_d.len_err) begin
        if (cnt_good != '1) cnt_good <= cnt_good + CNT_W'(1);
      end else begin
        if (cnt_bad != '1) cnt_bad <= cnt_bad + CNT_W'(1);
      end
    end
  end

  // Sticky framing error: data seen outside a frame.
  always_ff @(posedge clk) begin
    if (rst)            proto_err <= 1'b0;
    else if (proto_set) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Scoreboard bench: two checkers (MIN_LEN=0 with 3-bit counters, MIN_LEN=64 with
// 32-bit counters) share one stimulus stream. A frame-level reference model
// pushes expected output beats; a negedge monitor pops and compares.
module tb_eth_fcs_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_bcnt = '0;

  logic        o0_v, o0_sop, o0_eop, s0_v, s0_ok, s0_le, p0;
  logic [31:0] o0_d;
  logic [2:0]  o0_bc, c0_g, c0_b;
  logic        o1_v, o1_sop, o1_eop, s1_v, s1_ok, s1_le, p1;
  logic [31:0] o1_d, c1_g, c1_b;
  logic [2:0]  o1_bc;

  eth_fcs_checker #(.DATA_W(32), .MIN_LEN(0), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_bcnt(in_bcnt), .out_valid(o0_v), .out_sop(o0_sop),
    .out_eop(o0_eop), .out_data(o0_d), .out_bcnt(o0_bc), .stat_valid(s0_v),
    .stat_fcs_ok(s0_ok), .stat_len_err(s0_le), .cnt_good(c0_g), .cnt_bad(c0_b),
    .proto_err(p0));

  eth_fcs_checker #(.DATA_W(32), .MIN_LEN(64), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_bcnt(in_bcnt), .out_valid(o1_v), .out_sop(o1_sop),
    .out_eop(o1_eop), .out_data(o1_d), .out_bcnt(o1_bc), .stat_valid(s1_v),
    .stat_fcs_ok(s1_ok), .stat_len_err(s1_le), .cnt_good(c1_g), .cnt_bad(c1_b),
    .proto_err(p1));

  typedef struct {
    logic        sop, eop;
    logic [31:0] data;
    logic [2:0]  bcnt;
    logic        sv, ok, le;
    logic [31:0] cg, cb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model state
  bit          m_in_frame = 0;
  bit          m_proto    = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_good[2] = '{0, 0};
  logic [31:0] m_bad[2]  = '{0, 0};
  int          MINL[2]   = '{0, 64};
  logic [31:0] CMAX[2]   = '{32'd7, 32'hFFFFFFFF};

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %h expected %h (t=%0t)", i, nm, act, exp, $time);
    end
  endtask

  // Standard reflected Ethernet CRC-32 (init ~0, final inversion).
  function automatic logic [31:0] std_crc(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // A frame is good when its trailing 4 bytes are the little-endian CRC of the rest.
  function automatic bit frame_ok(input logic [7:0] q[$]);
    int n;
    n = q.size();
    if (n < 4) return 1'b0;
    return {q[n-1], q[n-2], q[n-3], q[n-4]} == std_crc(q, n - 4);
  endfunction

  task automatic m_count(input int i, input bit good);
    if (good) begin if (m_good[i] != CMAX[i]) m_good[i]++; end
    else      begin if (m_bad[i]  != CMAX[i]) m_bad[i]++;  end
  endtask

  // Drive one valid beat and record what each checker should emit for it.
  task automatic drive(input logic sop, input logic eop, input logic [31:0] d, input logic [2:0] bc);
    exp_t e[2];
    bit   trunc, badb, ok, le;
    int   n;
    @(negedge clk);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d; in_bcnt = bc;
    if (!m_in_frame && !sop) begin
      m_proto = 1'b1;
      return;
    end
    trunc = m_in_frame && sop;
    for (int i = 0; i < 2; i++) begin
      e[i].sop = sop; e[i].eop = eop; e[i].data = d; e[i].bcnt = bc;
      e[i].sv = trunc; e[i].ok = 1'b0; e[i].le = trunc;
      if (trunc) m_count(i, 1'b0);
    end
    if (sop) m_bytes.delete();
    badb = eop && (bc == 0 || bc > 4);
    n    = (eop && !badb) ? int'(bc) : 4;
    for (int k = 0; k < n; k++) m_bytes.push_back(d[8*k +: 8]);
    if (eop) begin
      if (!trunc) begin
        ok = frame_ok(m_bytes);
        for (int i = 0; i < 2; i++) begin
          le = badb || (m_bytes.size() < MINL[i]);
          e[i].sv = 1'b1; e[i].ok = ok; e[i].le = le;
          m_count(i, ok && !le);
        end
      end
      m_in_frame = 0;
    end else begin
      m_in_frame = 1;
    end
    for (int i = 0; i < 2; i++) begin e[i].cg = m_good[i]; e[i].cb = m_bad[i]; end
    q0.push_back(e[0]);
    q1.push_back(e[1]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = $urandom; in_bcnt = 3'($urandom);
  endtask

  task automatic make_frame(input int npay, input bit corrupt, output logic [7:0] f[$]);
    logic [31:0] c;
    f.delete();
    for (int i = 0; i < npay; i++) f.push_back(8'($urandom));
    c = std_crc(f, npay);
    f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
    if (corrupt) f[f.size()-1] = f[f.size()-1] ^ 8'h01;
  endtask

  // Split a byte list into beats; optional idle gaps and an illegal final bcnt.
  task automatic send_frame(input logic [7:0] f[$], input bit gaps, input bit badbc);
    int nb, rem;
    logic [31:0] d;
    logic [2:0]  bc;
    nb = (f.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      d   = $urandom;
      rem = f.size() - 4*b;
      for (int k = 0; k < 4; k++) if (k < rem) d[8*k +: 8] = f[4*b + k];
      if (b == nb - 1) begin
        bc = 3'(rem);
        if (badbc) bc = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      end else begin
        bc = 3'($urandom);
      end
      drive(b == 0, b == nb - 1, d, bc);
      if (gaps && $urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  task automatic mon(input int i, input logic v, input logic sop, input logic eop,
                     input logic [31:0] d, input logic [2:0] bc, input logic sv,
                     input logic ok, input logic le, input logic [31:0] cg, input logic [31:0] cb);
    exp_t e;
    bit   empty;
    if (!v && !sv) return;
    empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_chk++; n_err++;
      $display("FAIL u%0d unexpected output: valid=%b stat=%b with nothing expected (t=%0t)", i, v, sv, $time);
      return;
    end
    if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
    chk(i, "out_valid", 32'(v), 32'd1);
    chk(i, "out_sop/eop", {30'd0, sop, eop}, {30'd0, e.sop, e.eop});
    chk(i, "out_data", d, e.data);
    chk(i, "out_bcnt", 32'(bc), 32'(e.bcnt));
    chk(i, "stat_valid", 32'(sv), 32'(e.sv));
    if (e.sv) chk(i, "stat_ok/len_err", {30'd0, ok, le}, {30'd0, e.ok, e.le});
    chk(i, "cnt_good", cg, e.cg);
    chk(i, "cnt_bad", cb, e.cb);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, o0_v, o0_sop, o0_eop, o0_d, o0_bc, s0_v, s0_ok, s0_le, 32'(c0_g), 32'(c0_b));
      mon(1, o1_v, o1_sop, o1_eop, o1_d, o1_bc, s1_v, s1_ok, s1_le, c1_g, c1_b);
    end
  end

  task automatic chk_quiet(input string tag);
    chk(0, {tag, " proto_err"}, 32'(p0), 32'(m_proto));
    chk(1, {tag, " proto_err"}, 32'(p1), 32'(m_proto));
    chk(0, {tag, " cnt_good"}, 32'(c0_g), m_good[0]);
    chk(1, {tag, " cnt_bad"}, c1_b, m_bad[1]);
  endtask

  initial begin
    logic [7:0] f[$];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // reset state
    chk(0, "reset out_valid/stat", {30'd0, o0_v, s0_v}, 32'd0);
    chk(1, "reset out_valid/stat", {30'd0, o1_v, s1_v}, 32'd0);
    chk(0, "reset counters", {26'd0, c0_g, c0_b}, 32'd0);
    chk(1, "reset counters", c1_g | c1_b, 32'd0);
    chk(0, "reset proto_err", 32'(p0), 32'd0);

    // "123456789" with its known FCS, then with the last FCS byte corrupted
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(f, 0, 0);
    idle();
    chk(0, "check-string cnt_good", 32'(c0_g), 32'd1);
    f[12] = 8'hCA;
    send_frame(f, 0, 0);
    idle();
    chk(0, "bad-fcs cnt_bad", 32'(c0_b), 32'd1);

    // length boundary: 64 bytes legal, 63 bytes runt on the MIN_LEN=64 checker
    make_frame(60, 0, f); send_frame(f, 0, 0);
    make_frame(59, 0, f); send_frame(f, 1, 0);
    idle();
    chk(1, "min-len cnt_good", c1_g, 32'd1);

    // truncation: sop + 2 beats, then a new good frame
    drive(1, 0, $urandom, 3'd4);
    drive(0, 0, $urandom, 3'd4);
    drive(0, 0, $urandom, 3'd4);
    make_frame(64, 0, f); send_frame(f, 0, 0);

    // orphan eop and stray data beat while idle
    drive(0, 1, $urandom, 3'd2);
    idle();
    chk(0, "orphan proto_err", 32'(p0), 32'd1);
    drive(0, 0, $urandom, 3'd4);
    idle(); idle();
    chk_quiet("sticky");

    // illegal bcnt on eop, then enough bad frames to saturate the 3-bit counter
    make_frame(70, 0, f); send_frame(f, 0, 1);
    for (int n = 0; n < 8; n++) begin make_frame(8 + n, 1, f); send_frame(f, 0, 0); end
    idle();
    chk(0, "cnt_bad saturated", 32'(c0_b), 32'd7);

    // randomized frames
    for (int n = 0; n < 25; n++) begin
      make_frame($urandom_range(0, 96), $urandom_range(0, 2) == 0, f);
      send_frame(f, 1, $urandom_range(0, 7) == 0);
    end
    idle();
    chk_quiet("random");

    // reset mid-frame: no status, everything cleared
    drive(1, 0, $urandom, 3'd4);
    drive(0, 0, $urandom, 3'd4);
    idle(); idle();
    @(negedge clk); rst = 1'b1;
    m_in_frame = 0; m_proto = 0;
    m_good = '{0, 0}; m_bad = '{0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    chk(0, "post-rst counters", {26'd0, c0_g, c0_b}, 32'd0);
    chk(1, "post-rst counters", c1_g | c1_b, 32'd0);
    chk(1, "post-rst proto_err", 32'(p1), 32'd0);
    make_frame(80, 0, f); send_frame(f, 1, 0);
    idle(); idle();
    chk_quiet("final");
    chk(0, "drained", q0.size(), 32'd0);
    chk(1, "drained", q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
